address_sequencer: RTL and testbench

- Sequences the CPU address path through Z80-style machine cycles.
- Accepts one cycle request at a time: opcode fetch, memory read, memory write, stack push or stack pop.
- Drives the `ctl_*` controls of `address_latch`, plus the internal bus strobes. It inserts wait states and runs the refresh phase of M1.
- Sits between the instruction sequencer (requester) and `address_latch` / the pin drivers.

---
 rtl/addr_seq_pkg.sv | 70 +++++++
 rtl/addr_seq_decode.sv | 75 +++++++
 rtl/address_sequencer.sv | 80 ++++++++
 tb/tb_address_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_seq_pkg.sv
// Shared types and helpers for the Z80-style address sequencer.
// Request-type and state encodings, control bundle, incrementer mode decode.
// No timing or flow control of its own.
package addr_seq_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        MRD   = 3'd1,
        MWR   = 3'd2,
        PUSH  = 3'd3,
        POP   = 3'd4
    } req_type_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5
    } state_t;

    typedef struct packed {
        logic cy;
        logic dec;
    } inc_mode_t;

    typedef struct packed {
        logic al_we;
        logic bus_inc_oe;
        logic apin_mux;
        logic apin_mux2;
        logic inc_cy;
        logic inc_dec;
        logic inc_limit6;
        logic inc_zero;
        logic m1;
        logic mreq;
        logic rd;
        logic wr;
        logic rfsh;
        logic cycle_done;
    } ctl_t;

    function automatic logic is_read(input req_type_t t);
        return (t == FETCH) || (t == MRD) || (t == POP);
    endfunction

    function automatic inc_mode_t inc_mode(input req_type_t t);
        inc_mode_t m;
        m.cy  = (t == FETCH) || (t == POP) || (t == PUSH);
        m.dec = (t == PUSH);
        return m;
    endfunction

    // Unused encodings fall back to a plain memory read.
    function automatic req_type_t decode_type(input logic [2:0] code);
        req_type_t t;
        case (code)
            3'd0:    t = FETCH;
            3'd1:    t = MRD;
            3'd2:    t = MWR;
            3'd3:    t = PUSH;
            3'd4:    t = POP;
            default: t = MRD;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/addr_seq_decode.sv
// Combinational decode of (state, cycle type) into latch controls and bus strobes.
// Latency: zero, pure logic on registered inputs.
// Backpressure: none; consumer of the sequencer's registered state only.
module addr_seq_decode
    import addr_seq_pkg::*;
(
    input  state_t    state,
    input  req_type_t cyc_type,
    output ctl_t      ctl
);

    inc_mode_t mode;
    logic      rd_t;
    logic      fetch;

    assign mode  = inc_mode(cyc_type);
    assign rd_t  = is_read(cyc_type);
    assign fetch = (cyc_type == FETCH);

    always_comb begin
        ctl = '0;
        case (state)
            T1: begin
                ctl.al_we     = 1'b1;
                ctl.apin_mux2 = 1'b1;
                ctl.mreq      = 1'b1;
                ctl.rd        = rd_t;
                ctl.m1        = fetch;
                ctl.inc_cy    = mode.cy;
                ctl.inc_dec   = mode.dec;
            end
            T2, TW: begin
                ctl.apin_mux2  = 1'b1;
                ctl.mreq       = 1'b1;
                ctl.rd         = rd_t;
                ctl.wr         = !rd_t;
                ctl.m1         = fetch;
                // PC write-back happens once, in T2, never repeated during waits
                ctl.bus_inc_oe = fetch && (state == T2);
                ctl.inc_cy     = mode.cy;
                ctl.inc_dec    = mode.dec;
            end
            T3: begin
                if (fetch) begin
                    // refresh: latch IR from abus and step R within 7 bits
                    ctl.rfsh       = 1'b1;
                    ctl.mreq       = 1'b1;
                    ctl.al_we      = 1'b1;
                    ctl.apin_mux2  = 1'b1;
                    ctl.inc_limit6 = 1'b1;
                    ctl.inc_cy     = 1'b1;
                end else begin
                    ctl.apin_mux2  = 1'b1;
                    ctl.mreq       = 1'b1;
                    ctl.rd         = rd_t;
                    ctl.wr         = !rd_t;
                    ctl.bus_inc_oe = (cyc_type == PUSH) || (cyc_type == POP);
                    ctl.inc_cy     = mode.cy;
                    ctl.inc_dec    = mode.dec;
                    ctl.cycle_done = 1'b1;
                end
            end
            T4: begin
                ctl.rfsh       = 1'b1;
                ctl.apin_mux2  = 1'b1;
                ctl.inc_limit6 = 1'b1;
                ctl.inc_cy     = 1'b1;
                ctl.bus_inc_oe = 1'b1;
                ctl.cycle_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/address_sequencer.sv
// Runs Z80 machine cycles (fetch/read/write/push/pop) on the address path.
// Latency: 1 clock accept->T1; 3 (+waits) clocks per cycle, 4 (+waits) for FETCH.
// Backpressure: req_ready only in IDLE or the last T-state; pin_nwait stretches T2/TW.
module address_sequencer
    import addr_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_type,
    output logic       req_ready,
    input  logic       pin_nwait,
    output logic       ctl_al_we,
    output logic       ctl_bus_inc_oe,
    output logic       ctl_apin_mux,
    output logic       ctl_apin_mux2,
    output logic       ctl_inc_cy,
    output logic       ctl_inc_dec,
    output logic       ctl_inc_limit6,
    output logic       ctl_inc_zero,
    output logic       m1,
    output logic       mreq,
    output logic       rd,
    output logic       wr,
    output logic       rfsh,
    output logic       cycle_done
);

    state_t    state;
    req_type_t cyc_type;
    ctl_t      ctl;
    logic      accept;

    assign req_ready = !reset && ((state == IDLE) || ctl.cycle_done);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cyc_type <= MRD;
        end else begin
            if (accept) begin
                cyc_type <= decode_type(req_type);
            end
            case (state)
                IDLE:    if (accept) state <= T1;
                T1:      state <= T2;
                T2, TW:  state <= pin_nwait ? T3 : TW;
                T3: begin
                    if (cyc_type == FETCH) state <= T4;
                    else                   state <= accept ? T1 : IDLE;
                end
                T4:      state <= accept ? T1 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    addr_seq_decode u_decode (
        .state    (state),
        .cyc_type (cyc_type),
        .ctl      (ctl)
    );

    assign ctl_al_we      = ctl.al_we;
    assign ctl_bus_inc_oe = ctl.bus_inc_oe;
    assign ctl_apin_mux   = ctl.apin_mux;
    assign ctl_apin_mux2  = ctl.apin_mux2;
    assign ctl_inc_cy     = ctl.inc_cy;
    assign ctl_inc_dec    = ctl.inc_dec;
    assign ctl_inc_limit6 = ctl.inc_limit6;
    assign ctl_inc_zero   = ctl.inc_zero;
    assign m1             = ctl.m1;
    assign mreq           = ctl.mreq;
    assign rd             = ctl.rd;
    assign wr             = ctl.wr;
    assign rfsh           = ctl.rfsh;
    assign cycle_done     = ctl.cycle_done;

endmodule

// File: tb/tb_address_sequencer.sv
// Bench for address_sequencer: directed + random machine cycles against a phase-list reference model.
module tb_address_sequencer;

    localparam int P_IDLE = 0, P_T1 = 1, P_T2 = 2, P_TW = 3, P_T3 = 4, P_T4 = 5;
    localparam int C_FETCH = 0, C_MRD = 1, C_MWR = 2, C_PUSH = 3, C_POP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_type;
    logic       req_ready;
    logic       pin_nwait;
    logic       ctl_al_we, ctl_bus_inc_oe, ctl_apin_mux, ctl_apin_mux2;
    logic       ctl_inc_cy, ctl_inc_dec, ctl_inc_limit6, ctl_inc_zero;
    logic       m1, mreq, rd, wr, rfsh, cycle_done;

    logic [15:0] abus;
    logic [15:0] tb_latch;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  code;
        int          waits;
        logic [15:0] addr;
        logic [15:0] ir;
        int          gap;
    } tx_t;

    typedef struct {
        logic [15:0] vec;
        logic        nwait;
        logic [15:0] abus;
        logic        last;
        logic        wb_vld;
        logic [15:0] wb;
    } ph_t;

    tx_t tx_q[$];
    ph_t ph_q[$];

    always #5 clk = ~clk;

    address_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_type       (req_type),
        .req_ready      (req_ready),
        .pin_nwait      (pin_nwait),
        .ctl_al_we      (ctl_al_we),
        .ctl_bus_inc_oe (ctl_bus_inc_oe),
        .ctl_apin_mux   (ctl_apin_mux),
        .ctl_apin_mux2  (ctl_apin_mux2),
        .ctl_inc_cy     (ctl_inc_cy),
        .ctl_inc_dec    (ctl_inc_dec),
        .ctl_inc_limit6 (ctl_inc_limit6),
        .ctl_inc_zero   (ctl_inc_zero),
        .m1             (m1),
        .mreq           (mreq),
        .rd             (rd),
        .wr             (wr),
        .rfsh           (rfsh),
        .cycle_done     (cycle_done)
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] act_vec();
        return {1'b0, ctl_al_we, ctl_bus_inc_oe, ctl_apin_mux, ctl_apin_mux2, ctl_inc_cy,
                ctl_inc_dec, ctl_inc_limit6, ctl_inc_zero, m1, mreq, rd, wr, rfsh,
                cycle_done, req_ready};
    endfunction

    // What the latch/incrementer pair would put on abus under the current controls.
    function automatic logic [15:0] inc_out();
        logic [6:0] low;
        if (ctl_inc_limit6) begin
            low = tb_latch[6:0] + {6'd0, ctl_inc_cy};
            return {tb_latch[15:7], low};
        end
        if (ctl_inc_dec) return tb_latch - {15'd0, ctl_inc_cy};
        return tb_latch + {15'd0, ctl_inc_cy};
    endfunction

    // Expected control/strobe set for one T-state of a cycle of type t.
    function automatic logic [15:0] expvec(input int t, input int ph);
        bit fetch = (t == C_FETCH);
        bit rdt   = (t == C_FETCH) || (t == C_MRD) || (t == C_POP);
        bit cyt   = (t == C_FETCH) || (t == C_PUSH) || (t == C_POP);
        bit dect  = (t == C_PUSH);
        bit al_we = 0, oe = 0, mux2 = 0, cy = 0, dec = 0, lim = 0, m1e = 0;
        bit mrq = 0, rde = 0, wre = 0, rf = 0, done = 0, rdy = 0;
        case (ph)
            P_IDLE: rdy = 1;
            P_T1: begin
                al_we = 1; mux2 = 1; mrq = 1; rde = rdt; m1e = fetch; cy = cyt; dec = dect;
            end
            P_T2, P_TW: begin
                mux2 = 1; mrq = 1; rde = rdt; wre = !rdt; m1e = fetch;
                oe = fetch && (ph == P_T2); cy = cyt; dec = dect;
            end
            P_T3: begin
                if (fetch) begin
                    rf = 1; mrq = 1; al_we = 1; mux2 = 1; lim = 1; cy = 1;
                end else begin
                    mux2 = 1; mrq = 1; rde = rdt; wre = !rdt; oe = (t == C_PUSH) || (t == C_POP);
                    cy = cyt; dec = dect; done = 1; rdy = 1;
                end
            end
            P_T4: begin
                rf = 1; mux2 = 1; lim = 1; cy = 1; oe = 1; done = 1; rdy = 1;
            end
            default: ;
        endcase
        return {1'b0, al_we, oe, 1'b0, mux2, cy, dec, lim, 1'b0, m1e, mrq, rde, wre, rf, done, rdy};
    endfunction

    function automatic ph_t mk(input int t, input int ph);
        ph_t p;
        p.vec    = expvec(t, ph);
        p.nwait  = 1'($urandom);
        p.abus   = 16'($urandom);
        p.last   = 1'b0;
        p.wb_vld = 1'b0;
        p.wb     = 16'd0;
        return p;
    endfunction

    task automatic push_phases(input tx_t tx);
        int  t;
        ph_t p;
        t = (tx.code > 3'd4) ? C_MRD : int'(tx.code);
        p = mk(t, P_T1);
        p.abus = tx.addr;
        ph_q.push_back(p);
        p = mk(t, P_T2);
        p.nwait = (tx.waits == 0);
        if (t == C_FETCH) begin p.wb_vld = 1'b1; p.wb = tx.addr + 16'd1; end
        ph_q.push_back(p);
        for (int i = 0; i < tx.waits; i++) begin
            p = mk(t, P_TW);
            p.nwait = (i + 1 >= tx.waits);
            ph_q.push_back(p);
        end
        p = mk(t, P_T3);
        if (t == C_FETCH) p.abus = tx.ir;
        if (t == C_PUSH) begin p.wb_vld = 1'b1; p.wb = tx.addr - 16'd1; end
        if (t == C_POP)  begin p.wb_vld = 1'b1; p.wb = tx.addr + 16'd1; end
        p.last = (t != C_FETCH);
        ph_q.push_back(p);
        if (t == C_FETCH) begin
            p = mk(t, P_T4);
            p.wb_vld = 1'b1;
            p.wb     = {tx.ir[15:7], tx.ir[6:0] + 7'd1};
            p.last   = 1'b1;
            ph_q.push_back(p);
        end
    endtask

    task automatic add_tx(input int code, input int waits, input logic [15:0] addr,
                          input logic [15:0] ir, input int gap);
        tx_t tx;
        tx.code = 3'(code); tx.waits = waits; tx.addr = addr; tx.ir = ir; tx.gap = gap;
        tx_q.push_back(tx);
    endtask

    task automatic run_traffic(input int budget);
        int  cyc = 0;
        int  gap;
        bit  rdy;
        tx_t tx;
        gap = (tx_q.size() != 0) ? tx_q[0].gap : 0;
        while ((tx_q.size() != 0 || ph_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            chk("ctl", act_vec(), (ph_q.size() != 0) ? ph_q[0].vec : expvec(0, P_IDLE));
            if (ph_q.size() != 0 && ph_q[0].wb_vld) chk("wb", inc_out(), ph_q[0].wb);
            rdy       = (ph_q.size() == 0) || ph_q[0].last;
            pin_nwait = (ph_q.size() != 0) ? ph_q[0].nwait : 1'($urandom);
            abus      = (ph_q.size() != 0) ? ph_q[0].abus : 16'($urandom);
            if (ctl_al_we) tb_latch = abus;
            req_valid = 1'b0;
            req_type  = 3'($urandom);
            if (ph_q.size() != 0) void'(ph_q.pop_front());
            if (rdy && tx_q.size() != 0) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    tx = tx_q.pop_front();
                    req_valid = 1'b1;
                    req_type  = tx.code;
                    push_phases(tx);
                    gap = (tx_q.size() != 0) ? tx_q[0].gap : 0;
                end
            end
        end
        chk("drain", 16'(tx_q.size() + ph_q.size()), 16'd0);
        @(negedge clk);
        chk("idle", act_vec(), expvec(0, P_IDLE));
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_type  = 3'd0;
        pin_nwait = 1'b1;
        abus      = 16'd0;
        tb_latch  = 16'd0;
        #3;
        chk("rst0", act_vec(), 16'd0);
        repeat (3) @(negedge clk);
        chk("rst0_hold", act_vec(), 16'd0);
        reset = 1'b0;
        #1;
        chk("rst0_rel", act_vec(), expvec(0, P_IDLE));

        // Directed: plain read, PC/R wrap fetch, back-to-back POP/PUSH, waited MWR and FETCH.
        add_tx(C_MRD,   0, 16'h1234, 16'h0000, 0);
        add_tx(C_FETCH, 0, 16'hFFFF, 16'h007F, 2);
        add_tx(C_POP,   0, 16'h0000, 16'h0000, 1);
        add_tx(C_PUSH,  0, 16'h0000, 16'h0000, 0);
        add_tx(C_MWR,   2, 16'h8000, 16'h0000, 0);
        add_tx(C_FETCH, 2, 16'h4000, 16'h12FF, 0);
        add_tx(6,       1, 16'hABCD, 16'h0000, 0);
        for (int i = 0; i < 40; i++) begin
            add_tx($urandom_range(0, 7), $urandom_range(0, 3), 16'($urandom), 16'($urandom),
                   ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3));
        end
        run_traffic(5000);

        // Asynchronous reset in TW of a write cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = 3'(C_MWR);
        pin_nwait = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_t1", act_vec(), expvec(C_MWR, P_T1));
        @(negedge clk);
        chk("rst_t2", act_vec(), expvec(C_MWR, P_T2));
        @(negedge clk);
        chk("rst_tw", act_vec(), expvec(C_MWR, P_TW));
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", act_vec(), 16'd0);
        @(negedge clk);
        chk("rst_held", act_vec(), 16'd0);
        reset     = 1'b0;
        pin_nwait = 1'b1;
        #1;
        chk("rst_release", act_vec(), expvec(0, P_IDLE));
        add_tx(C_MRD, 0, 16'h5555, 16'h0000, 0);
        add_tx(C_POP, 1, 16'hFFFF, 16'h0000, 0);
        run_traffic(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
